// File: rtl/clock_pkg.sv
// Shared types and constants for the front-panel clock-setting controller.
//   set_state_t     : field-select FSM state, code equals the edit_field value
//   FIELD_*         : edit_field codes
//   BTN_SYNC_STAGES : flops in each button synchronizer
//   next_field()    : MODE-press successor state
//   field_code()    : edit_field value for a state
//   field_strobe()  : one-hot (active-high) strobe select, bit 0 = sec .. bit 5 = year
package clock_pkg;

  localparam int unsigned BTN_SYNC_STAGES = 2;

  localparam logic [2:0] FIELD_NONE = 3'd0;
  localparam logic [2:0] FIELD_SEC  = 3'd1;
  localparam logic [2:0] FIELD_MIN  = 3'd2;
  localparam logic [2:0] FIELD_HOUR = 3'd3;
  localparam logic [2:0] FIELD_DAY  = 3'd4;
  localparam logic [2:0] FIELD_MON  = 3'd5;
  localparam logic [2:0] FIELD_YEAR = 3'd6;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    E_SEC  = 3'd1,
    E_MIN  = 3'd2,
    E_HOUR = 3'd3,
    E_DAY  = 3'd4,
    E_MON  = 3'd5,
    E_YEAR = 3'd6
  } set_state_t;

  function automatic set_state_t next_field(input set_state_t s);
    set_state_t n;
    case (s)
      RUN:     n = E_SEC;
      E_SEC:   n = E_MIN;
      E_MIN:   n = E_HOUR;
      E_HOUR:  n = E_DAY;
      E_DAY:   n = E_MON;
      E_MON:   n = E_YEAR;
      default: n = RUN;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] field_code(input set_state_t s);
    logic [2:0] c;
    case (s)
      E_SEC:   c = FIELD_SEC;
      E_MIN:   c = FIELD_MIN;
      E_HOUR:  c = FIELD_HOUR;
      E_DAY:   c = FIELD_DAY;
      E_MON:   c = FIELD_MON;
      E_YEAR:  c = FIELD_YEAR;
      default: c = FIELD_NONE;
    endcase
    return c;
  endfunction

  function automatic logic [5:0] field_strobe(input set_state_t s);
    logic [5:0] v;
    case (s)
      E_SEC:   v = 6'b000001;
      E_MIN:   v = 6'b000010;
      E_HOUR:  v = 6'b000100;
      E_DAY:   v = 6'b001000;
      E_MON:   v = 6'b010000;
      E_YEAR:  v = 6'b100000;
      default: v = 6'b000000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Front-panel bus of the clock-setting controller.
//   btn_mode_n, btn_inc_n : raw active-low buttons (asynchronous)
//   tick_1hz              : one-clk pulse per second
//   run_en                : 1 = timekeeping allowed
//   edit_field            : 0 none, 1 sec .. 6 year
//   blink                 : display blink while editing
//   set_s .. set_y        : active-low one-clk increment strobes
// master = panel/environment side, slave = controller side.
interface clock_set_ctrl_if;
  logic       btn_mode_n;
  logic       btn_inc_n;
  logic       tick_1hz;
  logic       run_en;
  logic [2:0] edit_field;
  logic       blink;
  logic       set_s;
  logic       set_mi;
  logic       set_h;
  logic       set_d;
  logic       set_mon;
  logic       set_y;

  modport master (
    output btn_mode_n, btn_inc_n, tick_1hz,
    input  run_en, edit_field, blink, set_s, set_mi, set_h, set_d, set_mon, set_y
  );

  modport slave (
    input  btn_mode_n, btn_inc_n, tick_1hz,
    output run_en, edit_field, blink, set_s, set_mi, set_h, set_d, set_mon, set_y
  );
endinterface

// File: rtl/btn_debounce.sv
// Button conditioning: synchronizer, debounce counter and press-edge pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_n_i    : raw active-low button
//   level_o    : debounced level (1 = released)
//   press_o    : one-clk pulse on the debounced 1->0 edge
// A stable raw edge produces press_o DEB_CYCLES + 3 clk later.
module btn_debounce import clock_pkg::*; #(
  parameter logic [19:0] DEB_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic level_o,
  output logic press_o
);

  logic [BTN_SYNC_STAGES-1:0] sync_q, sync_d;
  logic [19:0]                cnt_q, cnt_d;
  logic                       level_q, level_d;
  logic                       level_dly_q;
  logic                       press_q, press_d;
  logic                       sync_out;

  assign sync_out = sync_q[BTN_SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[BTN_SYNC_STAGES-2:0], btn_n_i};
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_out == level_q) begin
      cnt_d = '0;
    end else if (cnt_q + 20'd1 >= DEB_CYCLES) begin
      // DEB_CYCLES consecutive differing samples: accept the new level
      cnt_d   = '0;
      level_d = sync_out;
    end else begin
      cnt_d = cnt_q + 20'd1;
    end
    press_d = level_dly_q & ~level_q;
  end

  // Idle (released) levels on reset so no spurious press follows reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '1;
      cnt_q       <= '0;
      level_q     <= 1'b1;
      level_dly_q <= 1'b1;
      press_q     <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Front-panel setting controller for the century clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : clock_set_ctrl_if.slave (buttons, tick_1hz, run_en, edit_field,
//                blink, active-low set_* strobes)
// MODE steps RUN -> sec -> min -> hour -> day -> month -> year -> RUN; INC
// strobes the selected field counter. Inactivity of TIMEOUT_S ticks returns to RUN.
// Optional build macro CLOCK_SET_AUTO_REPEAT_EN: holding INC auto-repeats one
// strobe per tick after REPEAT_DLY ticks.
module clock_set_ctrl import clock_pkg::*; #(
  parameter logic [19:0] DEB_CYCLES = 20'd500000,
  parameter logic [7:0]  TIMEOUT_S  = 8'd30,
  parameter logic [3:0]  REPEAT_DLY = 4'd2
) (
  input logic              clk,
  input logic              rst_n,
  clock_set_ctrl_if.slave  bus
);

  logic mode_press, mode_lvl;
  logic inc_press, inc_lvl;
  logic rep_fire;
  logic in_edit;

  set_state_t state_q, state_d;
  logic [7:0] to_cnt_q, to_cnt_d, to_cnt_inc;
  logic       blink_q, blink_d;
  logic [5:0] strb_q, strb_d;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n_i (bus.btn_mode_n),
    .level_o (mode_lvl),
    .press_o (mode_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n_i (bus.btn_inc_n),
    .level_o (inc_lvl),
    .press_o (inc_press)
  );

  assign in_edit = (state_q != RUN);

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  logic [3:0] rep_cnt_q, rep_cnt_d;
  logic       rep_cancel_q, rep_cancel_d;
  logic       unused_lvl;

  assign unused_lvl = mode_lvl;

  always_comb begin
    rep_cnt_d    = rep_cnt_q;
    rep_cancel_d = rep_cancel_q;
    rep_fire     = 1'b0;
    if (inc_lvl) begin
      // released: rearm
      rep_cnt_d    = '0;
      rep_cancel_d = 1'b0;
    end else if (mode_press) begin
      // MODE while INC held stops repeating until INC is released
      rep_cnt_d    = '0;
      rep_cancel_d = 1'b1;
    end else if (!in_edit) begin
      rep_cnt_d = '0;
    end else if (bus.tick_1hz && !rep_cancel_q) begin
      if (rep_cnt_q >= REPEAT_DLY) begin
        rep_fire = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q    <= '0;
      rep_cancel_q <= 1'b0;
    end else begin
      rep_cnt_q    <= rep_cnt_d;
      rep_cancel_q <= rep_cancel_d;
    end
  end
`else
  logic unused_lvl;

  assign unused_lvl = ^{mode_lvl, inc_lvl, REPEAT_DLY};
  assign rep_fire   = 1'b0;
`endif

  assign to_cnt_inc = (to_cnt_q == 8'hFF) ? 8'hFF : to_cnt_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    strb_d   = '0;
    if (mode_press) begin
      // MODE has priority; a coincident INC press is dropped
      state_d = next_field(state_q);
    end else if (in_edit && (inc_press || rep_fire)) begin
      strb_d   = field_strobe(state_q);
      to_cnt_d = '0;
    end else if (in_edit && bus.tick_1hz) begin
      to_cnt_d = to_cnt_inc;
      if (to_cnt_inc >= TIMEOUT_S) begin
        state_d = RUN;
      end
    end
    if (state_d != state_q) begin
      to_cnt_d = '0;
    end

    if (state_d != state_q) begin
      blink_d = 1'b0;
    end else if (in_edit && bus.tick_1hz) begin
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      to_cnt_q <= '0;
      blink_q  <= 1'b0;
      strb_q   <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      blink_q  <= blink_d;
      strb_q   <= strb_d;
    end
  end

  assign bus.run_en     = (state_q == RUN);
  assign bus.edit_field = field_code(state_q);
  assign bus.blink      = blink_q;
  assign bus.set_s      = ~strb_q[0];
  assign bus.set_mi     = ~strb_q[1];
  assign bus.set_h      = ~strb_q[2];
  assign bus.set_d      = ~strb_q[3];
  assign bus.set_mon    = ~strb_q[4];
  assign bus.set_y      = ~strb_q[5];

endmodule
